spell_ram_arbiter: RTL and testbench

SPELL_RAM_ARBITER -- requirements
Module: spell_ram_arbiter

---
 rtl/spell_ram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_spell_ram_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spell_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared wishbone RAM port.
// Optional ack timeout is built only when SPELL_ARB_TIMEOUT_EN is defined.
module spell_ram_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_cyc,
    input  logic [1:0]  req_we,
    input  logic [7:0]  req_sel,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_dat,
    output logic [1:0]  req_ack,
    output logic [1:0]  req_err,
    output logic [31:0] rsp_dat,
    output logic        ram_cyc,
    output logic        ram_stb,
    output logic        ram_we,
    output logic [3:0]  ram_sel,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_dat_o,
    input  logic        ram_ack,
    input  logic [31:0] ram_dat_i,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        ram_cyc_q, ram_cyc_d;
    logic        ram_we_q, ram_we_d;
    logic [3:0]  ram_sel_q, ram_sel_d;
    logic [7:0]  ram_addr_q, ram_addr_d;
    logic [31:0] ram_dat_q, ram_dat_d;
    logic [1:0]  req_ack_q, req_ack_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        win;
    logic        owner_req;

`ifdef SPELL_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = TIMEOUT_CYCLES - 8'd1;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic [1:0] req_err_q, req_err_d;
    logic       tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
    assign req_err = req_err_q;

    // Counter sits at zero in IDLE so every BUSY entry starts a fresh count.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == IDLE) begin
            tmo_cnt_d = 8'd0;
        end else if (state_q == BUSY && !ram_ack) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign req_err    = 2'b00;
`endif

    // A tie goes to whoever did not win last; a lone requester always wins.
    assign win       = (req_cyc == 2'b11) ? ~last_grant_q : req_cyc[1];
    assign owner_req = grant_q[1] ? req_cyc[1] : req_cyc[0];

    always_comb begin
        state_d      = state_q;
        ram_cyc_d    = ram_cyc_q;
        ram_we_d     = ram_we_q;
        ram_sel_d    = ram_sel_q;
        ram_addr_d   = ram_addr_q;
        ram_dat_d    = ram_dat_q;
        req_ack_d    = req_ack_q;
        rsp_dat_d    = rsp_dat_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
`ifdef SPELL_ARB_TIMEOUT_EN
        req_err_d    = req_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_cyc) begin
                    ram_cyc_d    = 1'b1;
                    ram_we_d     = win ? req_we[1] : req_we[0];
                    ram_sel_d    = win ? req_sel[7:4] : req_sel[3:0];
                    ram_addr_d   = win ? req_addr[15:8] : req_addr[7:0];
                    ram_dat_d    = win ? req_dat[63:32] : req_dat[31:0];
                    grant_d      = win ? 2'b10 : 2'b01;
                    last_grant_d = win;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                // Ack beats owner release, which beats timeout.
                if (ram_ack) begin
                    ram_cyc_d = 1'b0;
                    req_ack_d = grant_q;
                    rsp_dat_d = ram_dat_i;
                    state_d   = DONE;
                end else if (!owner_req) begin
                    ram_cyc_d = 1'b0;
                    grant_d   = 2'b00;
                    state_d   = IDLE;
                end
`ifdef SPELL_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    ram_cyc_d = 1'b0;
                    req_err_d = grant_q;
                    state_d   = DONE;
                end
`endif
            end
            DONE: begin
                req_ack_d = 2'b00;
                grant_d   = 2'b00;
`ifdef SPELL_ARB_TIMEOUT_EN
                req_err_d = 2'b00;
`endif
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ram_cyc_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_sel_q    <= 4'd0;
            ram_addr_q   <= 8'd0;
            ram_dat_q    <= 32'd0;
            req_ack_q    <= 2'b00;
            rsp_dat_q    <= 32'd0;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
`ifdef SPELL_ARB_TIMEOUT_EN
            req_err_q    <= 2'b00;
            tmo_cnt_q    <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            ram_cyc_q    <= ram_cyc_d;
            ram_we_q     <= ram_we_d;
            ram_sel_q    <= ram_sel_d;
            ram_addr_q   <= ram_addr_d;
            ram_dat_q    <= ram_dat_d;
            req_ack_q    <= req_ack_d;
            rsp_dat_q    <= rsp_dat_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
`ifdef SPELL_ARB_TIMEOUT_EN
            req_err_q    <= req_err_d;
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign ram_cyc   = ram_cyc_q;
    assign ram_stb   = ram_cyc_q;
    assign ram_we    = ram_we_q;
    assign ram_sel   = ram_sel_q;
    assign ram_addr  = ram_addr_q;
    assign ram_dat_o = ram_dat_q;
    assign req_ack   = req_ack_q;
    assign rsp_dat   = rsp_dat_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_spell_ram_arbiter.sv
// Directed self-checking bench for spell_ram_arbiter; timeout case adapts to SPELL_ARB_TIMEOUT_EN.
module tb_spell_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_cyc;
    logic [1:0]  req_we;
    logic [7:0]  req_sel;
    logic [15:0] req_addr;
    logic [63:0] req_dat;
    logic [1:0]  req_ack;
    logic [1:0]  req_err;
    logic [31:0] rsp_dat;
    logic        ram_cyc;
    logic        ram_stb;
    logic        ram_we;
    logic [3:0]  ram_sel;
    logic [7:0]  ram_addr;
    logic [31:0] ram_dat_o;
    logic        ram_ack;
    logic [31:0] ram_dat_i;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] exp_grant [4];

    always #5 clock = ~clock;

    spell_ram_arbiter #(.TIMEOUT_CYCLES(8'd4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_cyc   (req_cyc),
        .req_we    (req_we),
        .req_sel   (req_sel),
        .req_addr  (req_addr),
        .req_dat   (req_dat),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .rsp_dat   (rsp_dat),
        .ram_cyc   (ram_cyc),
        .ram_stb   (ram_stb),
        .ram_we    (ram_we),
        .ram_sel   (ram_sel),
        .ram_addr  (ram_addr),
        .ram_dat_o (ram_dat_o),
        .ram_ack   (ram_ack),
        .ram_dat_i (ram_dat_i),
        .grant     (grant)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_cyc   = 2'b00;
        req_we    = 2'b00;
        req_sel   = 8'h00;
        req_addr  = 16'h0000;
        req_dat   = 64'h0;
        ram_ack   = 1'b0;
        ram_dat_i = 32'h0;
        do_reset();

        check("rst_cyc",   ram_cyc,   1'b0);
        check("rst_stb",   ram_stb,   1'b0);
        check("rst_grant", grant,     2'b00);
        check("rst_ack",   req_ack,   2'b00);
        check("rst_err",   req_err,   2'b00);
        check("rst_rsp",   rsp_dat,   32'h0);
        check("rst_addr",  ram_addr,  8'h00);

        // Requester 0 read at 0x10, ack on the second BUSY cycle.
        req_cyc  = 2'b01;
        req_we   = 2'b00;
        req_sel  = 8'h0F;
        req_addr = 16'h0010;
        tick();
        check("rd_cyc",   ram_cyc,  1'b1);
        check("rd_stb",   ram_stb,  1'b1);
        check("rd_grant", grant,    2'b01);
        check("rd_addr",  ram_addr, 8'h10);
        check("rd_we",    ram_we,   1'b0);
        tick();
        check("rd_wait_cyc", ram_cyc, 1'b1);
        check("rd_wait_ack", req_ack, 2'b00);
        ram_ack   = 1'b1;
        ram_dat_i = 32'hDEADBEEF;
        tick();
        check("rd_ack",     req_ack, 2'b01);
        check("rd_rsp",     rsp_dat, 32'hDEADBEEF);
        check("rd_cyc_off", ram_cyc, 1'b0);
        ram_ack = 1'b0;
        req_cyc = 2'b00;
        tick();
        check("rd_ack_end",   req_ack, 2'b00);
        check("rd_grant_end", grant,   2'b00);

        // Both requesting, zero-wait RAM: grants must alternate from requester 0.
        do_reset();
        exp_grant[0] = 2'b01;
        exp_grant[1] = 2'b10;
        exp_grant[2] = 2'b01;
        exp_grant[3] = 2'b10;
        req_cyc   = 2'b11;
        ram_ack   = 1'b1;
        ram_dat_i = 32'h0BADF00D;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr_grant%0d", i), grant, exp_grant[i]);
            tick();
            check($sformatf("rr_ack%0d", i), req_ack, exp_grant[i]);
            tick();
            check($sformatf("rr_idle%0d", i), grant, 2'b00);
        end
        req_cyc = 2'b00;
        ram_ack = 1'b0;
        tick();

        // Requester 1 write; requester 0 fields hold unrelated values.
        req_cyc  = 2'b10;
        req_we   = 2'b10;
        req_sel  = 8'h3F;
        req_addr = 16'h3F77;
        req_dat  = 64'h0000ABCD_55555555;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wr_grant%0d", i), grant,     2'b10);
            check($sformatf("wr_we%0d", i),    ram_we,    1'b1);
            check($sformatf("wr_sel%0d", i),   ram_sel,   4'b0011);
            check($sformatf("wr_addr%0d", i),  ram_addr,  8'h3F);
            check($sformatf("wr_dat%0d", i),   ram_dat_o, 32'h0000ABCD);
            check($sformatf("wr_cyc%0d", i),   ram_cyc,   1'b1);
            tick();
        end
        ram_ack   = 1'b1;
        ram_dat_i = 32'h12345678;
        tick();
        check("wr_ack",  req_ack, 2'b10);
        check("wr_rsp",  rsp_dat, 32'h12345678);
        ram_ack = 1'b0;
        req_cyc = 2'b00;
        req_we  = 2'b00;
        tick();

        // Owner releases in the second BUSY cycle with no ack.
        req_cyc  = 2'b01;
        req_addr = 16'h0055;
        tick();
        tick();
        check("rel_busy", ram_cyc, 1'b1);
        req_cyc = 2'b00;
        tick();
        check("rel_cyc",   ram_cyc, 1'b0);
        check("rel_stb",   ram_stb, 1'b0);
        check("rel_ack",   req_ack, 2'b00);
        check("rel_err",   req_err, 2'b00);
        check("rel_grant", grant,   2'b00);
        tick();
        check("rel_ack2", req_ack, 2'b00);
        req_cyc = 2'b01;
        tick();
        check("rel_regrant", grant, 2'b01);
        req_cyc = 2'b00;
        tick();
        check("rel_regrant_drop", ram_cyc, 1'b0);

        // No ack at all: timeout after four BUSY cycles when built in, else wait forever.
        req_cyc  = 2'b01;
        req_addr = 16'h0022;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("tmo_cyc%0d", i), ram_cyc, 1'b1);
            check($sformatf("tmo_err%0d", i), req_err, 2'b00);
        end
`ifdef SPELL_ARB_TIMEOUT_EN
        tick();
        check("tmo_drop", ram_cyc, 1'b0);
        check("tmo_err",  req_err, 2'b01);
        check("tmo_ack",  req_ack, 2'b00);
        check("tmo_rsp",  rsp_dat, 32'h12345678);
        tick();
        check("tmo_err_end", req_err, 2'b00);
        check("tmo_idle",    grant,   2'b00);
        tick();
        check("tmo_next_grant", grant, 2'b01);
        ram_ack   = 1'b1;
        ram_dat_i = 32'hA5A5A5A5;
        tick();
        check("tmo_next_ack", req_ack, 2'b01);
        check("tmo_next_rsp", rsp_dat, 32'hA5A5A5A5);
        ram_ack = 1'b0;
        req_cyc = 2'b00;
        tick();
`else
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("nto_cyc%0d", i), ram_cyc, 1'b1);
            check($sformatf("nto_err%0d", i), req_err, 2'b00);
        end
        req_cyc = 2'b00;
        tick();
        check("nto_rel", ram_cyc, 1'b0);
`endif
        tick();

        // Reset collides with ram_ack mid-BUSY.
        req_cyc  = 2'b10;
        req_we   = 2'b10;
        req_sel  = 8'hF0;
        req_addr = 16'h9900;
        req_dat  = 64'hFFFFFFFF_00000000;
        tick();
        check("rb_busy", ram_cyc, 1'b1);
        reset     = 1'b1;
        ram_ack   = 1'b1;
        ram_dat_i = 32'hCAFEF00D;
        tick();
        check("rb_cyc",   ram_cyc,   1'b0);
        check("rb_stb",   ram_stb,   1'b0);
        check("rb_we",    ram_we,    1'b0);
        check("rb_sel",   ram_sel,   4'h0);
        check("rb_addr",  ram_addr,  8'h00);
        check("rb_dat",   ram_dat_o, 32'h0);
        check("rb_ack",   req_ack,   2'b00);
        check("rb_err",   req_err,   2'b00);
        check("rb_rsp",   rsp_dat,   32'h0);
        check("rb_grant", grant,     2'b00);
        reset   = 1'b0;
        ram_ack = 1'b0;
        req_cyc = 2'b00;
        req_we  = 2'b00;
        tick();
        check("rb_no_ack", req_ack, 2'b00);

        // last_grant is back at requester 1, so requester 0 takes the tie.
        req_cyc = 2'b11;
        tick();
        check("rb_tie_grant", grant, 2'b01);
        req_cyc = 2'b00;
        tick();
        check("rb_tie_drop", ram_cyc, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
